// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle arithmetic/logic ops, plus an iterative
// shift-add multiplier and a restoring divider that each take WIDTH cycles.
// Results and flags hold until the next completed operation.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       nzvc
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand (mul) or divisor (div/mod)
    logic [WIDTH:0]   hi_q, hi_d;          // partial product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;          // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       nzvc_q, nzvc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             iter_op_c;
    logic             last_c;
    logic [WIDTH:0]   add_c;
    logic [WIDTH:0]   sub_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   mul_hi_c;
    logic [WIDTH-1:0] mul_lo_c;
    logic [WIDTH:0]   div_sh_c;
    logic             div_ge_c;
    logic [WIDTH:0]   div_hi_c;
    logic [WIDTH-1:0] div_lo_c;

    logic [WIDTH-1:0] sc_res_c, sc_hi_c;
    logic [3:0]       sc_nzvc_c;
    logic             sc_v_c, sc_c_c;
    logic [WIDTH-1:0] it_res_c, it_hi_c;
    logic [3:0]       it_nzvc_c;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign nzvc      = nzvc_q;

    // Divide/modulo by zero is resolved immediately instead of iterating.
    assign iter_op_c = (op == OP_MUL) ||
                       (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
    assign last_c    = (cnt_q == CW'(WIDTH - 1));

    assign add_c = {1'b0, a} + {1'b0, b};
    assign sub_c = {1'b0, a} - {1'b0, b};

    // One shift-add step: add multiplicand when the current multiplier LSB is set,
    // then shift the {hi,lo} pair right so the next multiplier bit lands at lo[0].
    assign mul_sum_c = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_c  = {1'b0, mul_sum_c[WIDTH:1]};
    assign mul_lo_c  = {mul_sum_c[0], lo_q[WIDTH-1:1]};

    // One restoring-division step: shift the next dividend bit into the remainder,
    // subtract the divisor only if it fits, and shift the outcome bit into lo.
    assign div_sh_c = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign div_ge_c = (div_sh_c >= {1'b0, opnd_q});
    assign div_hi_c = div_ge_c ? (div_sh_c - {1'b0, opnd_q}) : div_sh_c;
    assign div_lo_c = {lo_q[WIDTH-2:0], div_ge_c};

    // Result and flags for operations completed at the accept edge.
    always_comb begin
        sc_res_c  = '0;
        sc_hi_c   = '0;
        sc_v_c    = 1'b0;
        sc_c_c    = 1'b0;
        sc_nzvc_c = 4'b0000;
        case (op)
            OP_ADD: begin
                sc_res_c = add_c[WIDTH-1:0];
                sc_c_c   = add_c[WIDTH];
                sc_v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (add_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_c = sub_c[WIDTH-1:0];
                sc_c_c   = sub_c[WIDTH];
                sc_v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_res_c = a & b;
            OP_OR:  sc_res_c = a | b;
            OP_NOT: sc_res_c = ~a;
            OP_XOR: sc_res_c = a ^ b;
            OP_CMP: sc_res_c = '0;
            // Only reached with b == 0; non-zero divisors take the iterative path.
            OP_DIV, OP_MOD: begin
                sc_res_c = '1;
                sc_hi_c  = '1;
            end
            default: sc_res_c = '1;
        endcase
        sc_nzvc_c = {sc_res_c[WIDTH-1], (sc_res_c == '0), sc_v_c, sc_c_c};
        case (op)
            OP_CMP:         sc_nzvc_c = {1'b0, (a == b), 1'b0, (a < b)};
            OP_ADD, OP_SUB,
            OP_AND, OP_OR,
            OP_NOT, OP_XOR: ;
            default:        sc_nzvc_c = 4'b1111;
        endcase
    end

    // Result and flags produced by the final iteration step.
    always_comb begin
        it_res_c  = '0;
        it_hi_c   = '0;
        it_nzvc_c = 4'b0000;
        case (op_q)
            OP_MUL: begin
                it_res_c = mul_lo_c;
                it_hi_c  = mul_hi_c[WIDTH-1:0];
            end
            OP_DIV: begin
                it_res_c = div_lo_c;
                it_hi_c  = div_hi_c[WIDTH-1:0];
            end
            default: begin
                it_res_c = div_hi_c[WIDTH-1:0];
                it_hi_c  = '0;
            end
        endcase
        it_nzvc_c = {it_res_c[WIDTH-1], (it_res_c == '0),
                     (op_q == OP_MUL) && (it_hi_c != '0), 1'b0};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; starts are only seen outside ITER, so FINISH accepts back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_d = iter_op_c ? S_ITER : S_FINISH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (last_c) begin
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d       = cnt_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        nzvc_d      = nzvc_q;
        done_d      = 1'b0;
        busy_d      = (state_d == S_ITER);
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    hi_d   = '0;
                    opnd_d = (op == OP_MUL) ? a : b;
                    lo_d   = (op == OP_MUL) ? b : a;
                    if (!iter_op_c) begin
                        result_d    = sc_res_c;
                        result_hi_d = sc_hi_c;
                        nzvc_d      = sc_nzvc_c;
                        done_d      = 1'b1;
                    end
                end
            end
            S_ITER: begin
                cnt_d = CW'(cnt_q + 1'b1);
                if (op_q == OP_MUL) begin
                    hi_d = mul_hi_c;
                    lo_d = mul_lo_c;
                end else begin
                    hi_d = div_hi_c;
                    lo_d = div_lo_c;
                end
                if (last_c) begin
                    cnt_d       = '0;
                    result_d    = it_res_c;
                    result_hi_d = it_hi_c;
                    nzvc_d      = it_nzvc_c;
                    done_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_q        <= '0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            nzvc_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            nzvc_q      <= nzvc_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors plus randomized operations against an arithmetic model.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   nzvc;

    int checks = 0;
    int errors = 0;

    int unsigned last_r, last_h;
    logic [3:0]  last_f;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .nzvc      (nzvc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: results straight from integer arithmetic and the flag rules.
    task automatic model(input logic [3:0] o, input int unsigned x, input int unsigned y,
                         output int unsigned r, output int unsigned h,
                         output logic [3:0] f, output int lat);
        int unsigned mask;
        int          sx, sy, s, smax, smin;
        bit          v, c, std;
        mask = (1 << W) - 1;
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        sx   = (x > int'(smax)) ? int'(x) - (1 << W) : int'(x);
        sy   = (y > int'(smax)) ? int'(y) - (1 << W) : int'(y);
        v = 0; c = 0; std = 1; h = 0; r = 0; f = 4'b0000; lat = 1;
        case (o)
            4'd0: begin r = (x + y) & mask; c = (x + y) > mask; s = sx + sy; v = (s > smax) || (s < smin); end
            4'd1: begin r = (x - y) & mask; c = (x < y); s = sx - sy; v = (s > smax) || (s < smin); end
            4'd2: begin r = (x * y) & mask; h = (x * y) >> W; v = (h != 0); lat = W + 1; end
            4'd3, 4'd4: begin
                if (y == 0) begin
                    r = mask; h = mask; f = 4'b1111; std = 0;
                end else begin
                    lat = W + 1;
                    if (o == 4'd3) begin r = x / y; h = x % y; end
                    else           begin r = x % y; h = 0; end
                end
            end
            4'd5: begin r = 0; f = {1'b0, x == y, 1'b0, x < y}; std = 0; end
            4'd6: r = x & y;
            4'd7: r = x | y;
            4'd8: r = ~x & mask;
            4'd9: r = x ^ y;
            default: begin r = mask; f = 4'b1111; std = 0; end
        endcase
        if (std) f = {((r >> (W - 1)) & 1) == 1, r == 0, v, c};
    endtask

    // Issue one op at the current negedge and follow it to its done cycle.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit noisy);
        int unsigned er, eh;
        logic [3:0]  ef;
        int          elat, cyc, bcnt;
        model(o, x, y, er, eh, ef, elat);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; bcnt = 0;
        while (!done && cyc < int'(W) + 4) begin
            if (busy) bcnt++;
            if (noisy && busy) begin
                start = 1'($urandom); op = 4'($urandom); a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_lat"},  cyc, elat);
        check({tag, "_busy"}, bcnt, elat - 1);
        check({tag, "_bdn"},  busy, 1'b0);
        check({tag, "_res"},  result, er);
        check({tag, "_hi"},   result_hi, eh);
        check({tag, "_nzvc"}, nzvc, ef);
        last_r = er; last_h = eh; last_f = ef;
    endtask

    // One idle cycle after done: pulse gone, outputs held.
    task automatic hold_check(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done0"}, done, 1'b0);
        check({tag, "_hres"},  result, last_r);
        check({tag, "_hhi"},   result_hi, last_h);
        check({tag, "_hnzvc"}, nzvc, last_f);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_res",  result, 0);
        check("rst_hi",   result_hi, 0);
        check("rst_nzvc", nzvc, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add", 4'd0, 8'h7F, 8'h01, 1'b0);
        check("add_lit_res", result, 8'h80);
        check("add_lit_nzvc", nzvc, 4'b1010);
        hold_check("add");

        run_op("sub", 4'd1, 8'h00, 8'h01, 1'b0);
        check("sub_lit_res", result, 8'hFF);
        check("sub_lit_nzvc", nzvc, 4'b1001);
        run_op("cmp", 4'd5, 8'h05, 8'h09, 1'b0);
        check("cmp_lit_res", result, 8'h00);
        check("cmp_lit_nzvc", nzvc, 4'b0001);
        hold_check("cmp");

        run_op("mul", 4'd2, 8'h10, 8'h10, 1'b0);
        check("mul_lit_res", result, 8'h00);
        check("mul_lit_hi", result_hi, 8'h01);
        check("mul_lit_nzvc", nzvc, 4'b0110);
        run_op("mulff", 4'd2, 8'hFF, 8'hFF, 1'b0);
        check("mulff_lit_res", result, 8'h01);
        check("mulff_lit_hi", result_hi, 8'hFE);
        check("mulff_lit_v", nzvc[1], 1'b1);

        run_op("div", 4'd3, 8'd200, 8'd7, 1'b0);
        check("div_lit_res", result, 8'h1C);
        check("div_lit_hi", result_hi, 8'h04);
        check("div_lit_nzvc", nzvc, 4'b0000);
        hold_check("div");
        run_op("div0", 4'd3, 8'd200, 8'd0, 1'b0);
        check("div0_lit_res", result, 8'hFF);
        check("div0_lit_nzvc", nzvc, 4'b1111);
        hold_check("div0");

        // Starts during a running mul are ignored; a start in its done cycle is taken.
        run_op("mulnz", 4'd2, 8'h0D, 8'h0B, 1'b1);
        run_op("b2b", 4'd0, 8'h12, 8'h34, 1'b0);
        check("b2b_lit_res", result, 8'h46);
        hold_check("b2b");

        // Reset in the fourth ITER cycle of a divide.
        op = 4'd3; a = 8'd200; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_res",  result, 0);
        check("arst_hi",   result_hi, 0);
        check("arst_nzvc", nzvc, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("arst_nodone", dcount, 0);
        run_op("post", 4'd0, 8'h21, 8'h03, 1'b0);
        check("post_lit_res", result, 8'h24);

        for (int i = 0; i < 250; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] rx, ry;
            ro = 4'($urandom_range(0, 15));
            rx = W'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op("rnd", ro, rx, ry, 1'($urandom));
            if ($urandom_range(0, 2) == 0) hold_check("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
